// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer: fetches one word per request,
// holds it for decode until commit, then steps the PC. Optional feature macro: PC_MISALIGN_TRAP_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        commit,
  input  logic [2:0]  branch,
  input  logic        zero,
  input  logic        less,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] instret,
  output logic        trap
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instret_reg, instret_next;
  logic [31:0] target_pc;

  // Branch/jump target from the inputs sampled in the commit cycle.
  always_comb begin
    target_pc = pc_reg + 32'd4;
    case (branch)
      3'b001: target_pc = pc_reg + imm;
      3'b010: target_pc = (rs1 + imm) & ~32'h0000_0001;
      3'b100: if (zero)  target_pc = pc_reg + imm;
      3'b101: if (!zero) target_pc = pc_reg + imm;
      3'b110: if (less)  target_pc = pc_reg + imm;
      3'b111: if (!less) target_pc = pc_reg + imm;
      default: target_pc = pc_reg + 32'd4;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    instr_next   = instr_reg;
    instret_next = instret_reg;
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (commit) begin
`ifdef PC_MISALIGN_TRAP_EN
          // A halfword-aligned target faults; pc keeps the faulting instruction.
          if (target_pc[1]) begin
            state_next = TRAP;
          end else begin
            pc_next      = target_pc;
            instret_next = instret_reg + 32'd1;
            state_next   = FETCH;
          end
`else
          pc_next      = target_pc & ~32'h0000_0003;
          instret_next = instret_reg + 32'd1;
          state_next   = FETCH;
`endif
        end
      end
      TRAP: state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      instr_reg   <= NOP;
      instret_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      instret_reg <= instret_next;
    end
  end

  // Handshake outputs come straight from the state register so they never glitch.
  assign imem_req    = (state_reg == FETCH);
  assign instr_valid = (state_reg == EXEC);
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instret     = instret_reg;
`ifdef PC_MISALIGN_TRAP_EN
  assign trap = (state_reg == TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch; honours PC_MISALIGN_TRAP_EN when defined.
module tb_pc_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        commit = 1'b0;
  logic [2:0]  branch = 3'd0;
  logic        zero = 1'b0;
  logic        less = 1'b0;
  logic [31:0] imm = 32'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] instret;
  logic        trap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .commit(commit), .branch(branch), .zero(zero), .less(less), .imm(imm), .rs1(rs1),
    .instret(instret), .trap(trap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; commit = 1'b0; branch = 3'd0; zero = 1'b0; less = 1'b0;
    imm = 32'd0; rs1 = 32'd0; imem_rdata = 32'd0;
    #2;
    tick();
    rst_n = 1'b1;
  endtask

  // Reset, then step out of IDLE so the DUT sits in FETCH at RESET_PC.
  task automatic start();
    apply_reset();
    tick();
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic retire(input logic [2:0] br, input logic z, input logic l,
                        input logic [31:0] im, input logic [31:0] r);
    commit = 1'b1; branch = br; zero = z; less = l; imm = im; rs1 = r;
    tick();
    commit = 1'b0; branch = 3'd0;
    $display("commit br=%b zero=%b less=%b imm=%h rs1=%h -> pc=%h instret=%0d trap=%b",
             br, z, l, im, r, pc, instret, trap);
  endtask

  task automatic goto(input logic [31:0] target);
    start();
    fetch(NOP);
    retire(3'b001, 1'b0, 1'b0, target, 32'd0);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'd0); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr, NOP); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %h want 0", instret); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b want 0", trap); end
    tick();
    rst_n = 1'b1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL first_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] word;
    for (int i = 0; i < 3; i++) begin
      word = 32'h00a0_0093 + i;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] got %b want 1", i, imem_req); end
      checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr, 32'(4 * i)); end
      fetch(word);
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL seq_valid[%0d] got valid=%b req=%b want 1/0", i, instr_valid, imem_req); end
      checks++; if (instr !== word) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, instr, word); end
      retire(3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL seq_instret got %0d want 3", instret); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd12) begin errors++; $display("FAIL seq_next got req=%b addr=%h want 1/%h", imem_req, imem_addr, 32'd12); end
  endtask

  task automatic test_wait_states();
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd12 || instr_valid !== 1'b0) begin errors++; $display("FAIL wait_hold[%0d] got req=%b addr=%h valid=%b want 1/%h/0", k, imem_req, imem_addr, instr_valid, 32'd12); end
      tick();
    end
    checks++; if (imem_addr !== 32'd12) begin errors++; $display("FAIL wait_addr_last got %h want %h", imem_addr, 32'd12); end
    fetch(32'hDEAD_BEEF);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wait_valid got %b want 1", instr_valid); end
    checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait_instr got %h want %h", instr, 32'hDEAD_BEEF); end
    retire(3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (pc !== 32'd16) begin errors++; $display("FAIL wait_pc got %h want %h", pc, 32'd16); end
  endtask

  task automatic test_branches();
    logic [2:0]  br_tab  [9] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b100, 3'b101, 3'b111, 3'b000, 3'b011};
    logic        z_tab   [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        l_tab   [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_tab [9] = '{32'hF0, 32'h104, 32'hF0, 32'h104, 32'h104, 32'hF0, 32'hF0, 32'h104, 32'h104};
    for (int i = 0; i < 9; i++) begin
      goto(32'h100);
      fetch(NOP);
      retire(br_tab[i], z_tab[i], l_tab[i], 32'hFFFF_FFF0, 32'd0);
      checks++; if (pc !== exp_tab[i]) begin errors++; $display("FAIL branch[%0d] br=%b got %h want %h", i, br_tab[i], pc, exp_tab[i]); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_tab[i]) begin errors++; $display("FAIL branch_fetch[%0d] got req=%b addr=%h want 1/%h", i, imem_req, imem_addr, exp_tab[i]); end
    end
  endtask

  task automatic test_jumps();
    goto(32'h20);
    fetch(NOP);
    retire(3'b001, 1'b0, 1'b0, 32'h40, 32'd0);
    checks++; if (pc !== 32'h60) begin errors++; $display("FAIL jal got %h want %h", pc, 32'h60); end
    fetch(NOP);
    retire(3'b010, 1'b0, 1'b0, 32'h4, 32'h1001);
    checks++; if (pc !== 32'h1004) begin errors++; $display("FAIL jalr got %h want %h", pc, 32'h1004); end
    fetch(NOP);
    retire(3'b010, 1'b0, 1'b0, 32'h0, 32'h1002);
`ifdef PC_MISALIGN_TRAP_EN
    checks++; if (trap !== 1'b1) begin errors++; $display("FAIL jalr_trap got %b want 1", trap); end
    checks++; if (pc !== 32'h1004) begin errors++; $display("FAIL jalr_trap_pc got %h want %h", pc, 32'h1004); end
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL jalr_trap_hs got req=%b valid=%b want 0/0", imem_req, instr_valid); end
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL jalr_trap_instret got %0d want 3", instret); end
    imem_ack = 1'b1; commit = 1'b1;
    tick(); tick();
    imem_ack = 1'b0; commit = 1'b0;
    checks++; if (trap !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h1004) begin errors++; $display("FAIL trap_sticky got trap=%b req=%b pc=%h want 1/0/%h", trap, imem_req, pc, 32'h1004); end
`else
    checks++; if (pc !== 32'h1000) begin errors++; $display("FAIL jalr_align got %h want %h", pc, 32'h1000); end
    checks++; if (trap !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL jalr_align_hs got trap=%b req=%b want 0/1", trap, imem_req); end
    checks++; if (instret !== 32'd4) begin errors++; $display("FAIL jalr_align_instret got %0d want 4", instret); end
`endif
  endtask

  task automatic test_async_reset();
    goto(32'h200);
    fetch(32'h1234_5678);
    rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL areset_exec_valid got %b want 0", instr_valid); end
    checks++; if (pc !== 32'd0 || instr !== NOP || instret !== 32'd0) begin errors++; $display("FAIL areset_exec_state got pc=%h instr=%h instret=%0d want 0/%h/0", pc, instr, instret, NOP); end
    tick();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL areset_fetch_req got %b want 0", imem_req); end
    tick();
    imem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr !== NOP) begin errors++; $display("FAIL areset_restart got req=%b addr=%h instr=%h want 1/0/%h", imem_req, imem_addr, instr, NOP); end
  endtask

  task automatic test_ignored_and_wrap();
    start();
    commit = 1'b1; branch = 3'b001; imm = 32'h80;
    tick();
    commit = 1'b0; branch = 3'b000;
    checks++; if (imem_req !== 1'b1 || pc !== 32'd0 || instret !== 32'd0) begin errors++; $display("FAIL spurious_commit got req=%b pc=%h instret=%0d want 1/0/0", imem_req, pc, instret); end
    fetch(32'h1111_1111);
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h1111_1111 || pc !== 32'd0) begin errors++; $display("FAIL spurious_ack got valid=%b instr=%h pc=%h want 1/%h/0", instr_valid, instr, pc, 32'h1111_1111); end
    retire(3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    force dut.instret_reg = 32'hFFFF_FFFF;
    #1;
    release dut.instret_reg;
    fetch(NOP);
    retire(3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL instret_wrap got %h want 0", instret); end
    checks++; if (pc !== 32'd8) begin errors++; $display("FAIL wrap_pc got %h want %h", pc, 32'd8); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_branches();
    test_jumps();
    test_async_reset();
    test_ignored_and_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
